// File: rtl/cache_stress_gen_pkg.sv
// ----------------------------------------------------------------------------
// cache_stress_pkg
// Shared definitions for the cache stress generator:
//   - FSM state encodings
//   - LFSR feedback polynomial and the preload data pattern
//   - lfsr_step(): one step of the 32-bit right-shifting Galois LFSR
// ----------------------------------------------------------------------------
package cache_stress_pkg;

    // FSM state encodings
    localparam logic [2:0] S_IDLE  = 3'd0;
    localparam logic [2:0] S_INIT  = 3'd1;
    localparam logic [2:0] S_GEN   = 3'd2;
    localparam logic [2:0] S_ISSUE = 3'd3;
    localparam logic [2:0] S_DONE  = 3'd4;

    // Galois feedback taps (maximal-length 32-bit polynomial)
    localparam logic [31:0] LFSR_POLY    = 32'h8020_0003;

    // Preload pattern; the low bits carry the word index
    localparam logic [31:0] INIT_PATTERN = 32'hA500_0000;

    // One right-shift Galois step: the bit shifted out selects the feedback.
    function automatic logic [31:0] lfsr_step(input logic [31:0] s);
        logic [31:0] n;
        n = s >> 1;
        if (s[0]) begin
            n = n ^ LFSR_POLY;
        end
        return n;
    endfunction

endpackage

// File: rtl/cache_stress_gen_if.sv
// ----------------------------------------------------------------------------
// cache_stress_gen_if
// CPU-side request bus between the stress generator and the cache.
//   cpu_addr        byte address of the request
//   cpu_rd / cpu_wr read / write request (held until accepted)
//   cpu_wr_be       byte enables for writes
//   cpu_wr_data     write data
//   cpu_rd_data     read data, valid in the accepting cycle of a read
//   cpu_waitrequest stall; a request completes at a posedge where it is low
// Modports: master = request issuer (generator), slave = cache side.
// ----------------------------------------------------------------------------
interface cache_stress_gen_if #(
    parameter int unsigned ADDR_WIDTH = 32,
    parameter int unsigned DATA_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]   cpu_addr;
    logic                    cpu_rd;
    logic                    cpu_wr;
    logic [DATA_WIDTH/8-1:0] cpu_wr_be;
    logic [DATA_WIDTH-1:0]   cpu_wr_data;
    logic [DATA_WIDTH-1:0]   cpu_rd_data;
    logic                    cpu_waitrequest;

    modport master (
        output cpu_addr, cpu_rd, cpu_wr, cpu_wr_be, cpu_wr_data,
        input  cpu_rd_data, cpu_waitrequest
    );

    modport slave (
        input  cpu_addr, cpu_rd, cpu_wr, cpu_wr_be, cpu_wr_data,
        output cpu_rd_data, cpu_waitrequest
    );
endinterface

// File: rtl/cache_stress_gen_shadow_ram.sv
// ----------------------------------------------------------------------------
// stress_shadow_ram
// Single-port synchronous RAM, 2^AW words x DW bits, holding the expected
// content of the region under test.
//   clk      clock
//   addr_i   word address (shared by read and write)
//   we_i     per-byte write enables
//   wdata_i  write data
//   re_i     read enable; rdata_o updates on the next posedge and then holds
//   rdata_o  registered read data
// ----------------------------------------------------------------------------
module stress_shadow_ram #(
    parameter int unsigned AW = 10,
    parameter int unsigned DW = 32
) (
    input  logic            clk,
    input  logic [AW-1:0]   addr_i,
    input  logic [DW/8-1:0] we_i,
    input  logic [DW-1:0]   wdata_i,
    input  logic            re_i,
    output logic [DW-1:0]   rdata_o
);
    logic [DW-1:0] mem [2**AW];
    logic [DW-1:0] rdata_q;

    always_ff @(posedge clk) begin
        for (int b = 0; b < DW / 8; b++) begin
            if (we_i[b]) begin
                mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
            end
        end
        // Held output: the compare happens several cycles after the read.
        if (re_i) begin
            rdata_q <= mem[addr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/cache_stress_gen.sv
// ----------------------------------------------------------------------------
// cache_stress_gen
// Self-checking traffic generator for the generic_cache CPU port. Preloads
// a region with a known pattern, then issues LFSR-random reads and writes,
// mirroring writes into a shadow RAM and checking every read against it.
//
// Ports:
//   clock, reset_n   clock, asynchronous active-low reset
//   start            pulse; accepted in IDLE or DONE only
//   n_tests          random transactions after preload (0 = endless)
//   busy / done      running / finished
//   timeout          sticky: a request stalled for TIMEOUT cycles
//   err_count        read mismatches (saturating)
//   rd_count         random reads completed
//   wr_count         random writes completed
//   max_latency      worst accept latency in cycles (saturating)
//   first_err_*      address / expected / returned data of first mismatch
//   cpu              request bus (master side)
// ----------------------------------------------------------------------------
module cache_stress_gen
    import cache_stress_pkg::*;
#(
    parameter int unsigned           ADDR_WIDTH = 32,
    parameter int unsigned           DATA_WIDTH = 32,
    parameter int unsigned           SHADOW_AW  = 10,
    parameter logic [ADDR_WIDTH-1:0] BASE_ADDR  = '0,
    parameter logic [31:0]           SEED       = 32'h1,
    parameter int                    RAND_BE    = 1,
    parameter int unsigned           TIMEOUT    = 1024
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start,
    input  logic [31:0]           n_tests,
    output logic                  busy,
    output logic                  done,
    output logic                  timeout,
    output logic [31:0]           err_count,
    output logic [31:0]           rd_count,
    output logic [31:0]           wr_count,
    output logic [15:0]           max_latency,
    output logic [ADDR_WIDTH-1:0] first_err_addr,
    output logic [DATA_WIDTH-1:0] first_err_exp,
    output logic [DATA_WIDTH-1:0] first_err_got,
    cache_stress_gen_if.master    cpu
);
    localparam int unsigned BEW    = DATA_WIDTH / 8;
    localparam int unsigned REP    = DATA_WIDTH / 32;
    localparam int unsigned OFFS_W = $clog2(BEW);

    // A zero seed would lock the LFSR; substitute 1.
    localparam logic [31:0] SEED_A = (SEED == 32'h0) ? 32'h1 : SEED;
    localparam logic [31:0] SEED_B = (~SEED == 32'h0) ? 32'h1 : ~SEED;

    // ------------------------------------------------------------------
    // State
    // ------------------------------------------------------------------
    logic [2:0]            state_q,    state_d;
    logic [SHADOW_AW-1:0]  idx_q,      idx_d;
    logic                  op_q,       op_d;      // 1 = read
    logic [BEW-1:0]        be_q,       be_d;
    logic [DATA_WIDTH-1:0] wdata_q,    wdata_d;
    logic [31:0]           lfsr_a_q,   lfsr_a_d;
    logic [31:0]           lfsr_b_q,   lfsr_b_d;
    logic [31:0]           lat_q,      lat_d;     // cycles already stalled
    logic [31:0]           ntests_q,   ntests_d;
    logic [31:0]           err_q,      err_d;
    logic [31:0]           rd_q,       rd_d;
    logic [31:0]           wr_q,       wr_d;
    logic [15:0]           maxlat_q,   maxlat_d;
    logic                  timeout_q,  timeout_d;
    logic [ADDR_WIDTH-1:0] fe_addr_q,  fe_addr_d;
    logic [DATA_WIDTH-1:0] fe_exp_q,   fe_exp_d;
    logic [DATA_WIDTH-1:0] fe_got_q,   fe_got_d;

    // ------------------------------------------------------------------
    // Shadow RAM
    // ------------------------------------------------------------------
    logic [SHADOW_AW-1:0]  ram_addr;
    logic [BEW-1:0]        ram_we;
    logic [DATA_WIDTH-1:0] ram_wdata;
    logic                  ram_re;
    logic [DATA_WIDTH-1:0] ram_rdata;

    stress_shadow_ram #(
        .AW (SHADOW_AW),
        .DW (DATA_WIDTH)
    ) u_shadow (
        .clk     (clock),
        .addr_i  (ram_addr),
        .we_i    (ram_we),
        .wdata_i (ram_wdata),
        .re_i    (ram_re),
        .rdata_o (ram_rdata)
    );

    // ------------------------------------------------------------------
    // Request decode
    // ------------------------------------------------------------------
    logic                  req_rd, req_wr, req, accept;
    logic [ADDR_WIDTH-1:0] req_addr;
    logic [DATA_WIDTH-1:0] init_word;
    logic [31:0]           lat_now;
    logic [15:0]           lat_sat;
    logic                  lat_expired;

    logic [31:0]           lfsr_a_n, lfsr_b_n;
    logic [SHADOW_AW-1:0]  idx_rand;
    logic [BEW-1:0]        be_rand;

    assign req_rd   = (state_q == S_ISSUE) && op_q;
    assign req_wr   = (state_q == S_INIT) || ((state_q == S_ISSUE) && !op_q);
    assign req      = req_rd || req_wr;
    assign accept   = req && !cpu.cpu_waitrequest;

    // Index is scaled by the word size, so accesses never leave the region.
    assign req_addr  = BASE_ADDR + (ADDR_WIDTH'(idx_q) << OFFS_W);
    assign init_word = {REP{INIT_PATTERN | 32'(idx_q)}};

    // Latency includes the accepting cycle.
    assign lat_now     = lat_q + 32'd1;
    assign lat_sat     = (lat_now > 32'h0000_FFFF) ? 16'hFFFF : lat_now[15:0];
    assign lat_expired = (lat_now >= 32'(TIMEOUT));

    // Index and byte enables come from the freshly stepped LFSR value.
    assign lfsr_a_n = lfsr_step(lfsr_a_q);
    assign lfsr_b_n = lfsr_step(lfsr_b_q);
    assign idx_rand = lfsr_a_n[SHADOW_AW:1];

    always_comb begin
        be_rand = lfsr_a_n[SHADOW_AW+BEW:SHADOW_AW+1];
        if ((RAND_BE == 0) || (be_rand == '0)) begin
            be_rand = '1;
        end
    end

    // ------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        op_d      = op_q;
        be_d      = be_q;
        wdata_d   = wdata_q;
        lfsr_a_d  = lfsr_a_q;
        lfsr_b_d  = lfsr_b_q;
        lat_d     = lat_q;
        ntests_d  = ntests_q;
        err_d     = err_q;
        rd_d      = rd_q;
        wr_d      = wr_q;
        maxlat_d  = maxlat_q;
        timeout_d = timeout_q;
        fe_addr_d = fe_addr_q;
        fe_exp_d  = fe_exp_q;
        fe_got_d  = fe_got_q;
        ram_addr  = idx_q;
        ram_we    = '0;
        ram_wdata = wdata_q;
        ram_re    = 1'b0;

        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_INIT;
                    idx_d     = '0;
                    lat_d     = '0;
                    lfsr_a_d  = SEED_A;
                    lfsr_b_d  = SEED_B;
                    ntests_d  = n_tests;
                    err_d     = '0;
                    rd_d      = '0;
                    wr_d      = '0;
                    maxlat_d  = '0;
                    timeout_d = 1'b0;
                    fe_addr_d = '0;
                    fe_exp_d  = '0;
                    fe_got_d  = '0;
                end
            end

            S_INIT: begin
                ram_wdata = init_word;
                if (accept) begin
                    ram_we = '1;
                    lat_d  = '0;
                    if (lat_sat > maxlat_q) begin
                        maxlat_d = lat_sat;
                    end
                    if (idx_q == '1) begin
                        state_d = S_GEN;
                    end else begin
                        idx_d = idx_q + SHADOW_AW'(1);
                    end
                end else if (lat_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    lat_d = lat_now;
                end
            end

            S_GEN: begin
                lfsr_a_d = lfsr_a_n;
                lfsr_b_d = lfsr_b_n;
                op_d     = lfsr_a_n[0];
                idx_d    = idx_rand;
                be_d     = be_rand;
                wdata_d  = {REP{lfsr_b_n}};
                ram_addr = idx_rand;
                ram_re   = 1'b1;
                lat_d    = '0;
                state_d  = S_ISSUE;
            end

            S_ISSUE: begin
                if (accept) begin
                    lat_d = '0;
                    if (lat_sat > maxlat_q) begin
                        maxlat_d = lat_sat;
                    end
                    if (op_q) begin
                        rd_d = rd_q + 32'd1;
                        if (cpu.cpu_rd_data != ram_rdata) begin
                            if (err_q != '1) begin
                                err_d = err_q + 32'd1;
                            end
                            if (err_q == '0) begin
                                fe_addr_d = req_addr;
                                fe_exp_d  = ram_rdata;
                                fe_got_d  = cpu.cpu_rd_data;
                            end
                        end
                    end else begin
                        // Shadow merge: only enabled lanes take the new data.
                        ram_we = be_q;
                        wr_d   = wr_q + 32'd1;
                    end
                    if ((ntests_q != '0) && (rd_q + wr_q + 32'd1 == ntests_q)) begin
                        state_d = S_DONE;
                    end else begin
                        state_d = S_GEN;
                    end
                end else if (lat_expired) begin
                    timeout_d = 1'b1;
                    state_d   = S_DONE;
                end else begin
                    lat_d = lat_now;
                end
            end

            default: state_d = S_IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= S_IDLE;
            idx_q     <= '0;
            op_q      <= 1'b0;
            be_q      <= '0;
            wdata_q   <= '0;
            lfsr_a_q  <= SEED_A;
            lfsr_b_q  <= SEED_B;
            lat_q     <= '0;
            ntests_q  <= '0;
            err_q     <= '0;
            rd_q      <= '0;
            wr_q      <= '0;
            maxlat_q  <= '0;
            timeout_q <= 1'b0;
            fe_addr_q <= '0;
            fe_exp_q  <= '0;
            fe_got_q  <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            op_q      <= op_d;
            be_q      <= be_d;
            wdata_q   <= wdata_d;
            lfsr_a_q  <= lfsr_a_d;
            lfsr_b_q  <= lfsr_b_d;
            lat_q     <= lat_d;
            ntests_q  <= ntests_d;
            err_q     <= err_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            maxlat_q  <= maxlat_d;
            timeout_q <= timeout_d;
            fe_addr_q <= fe_addr_d;
            fe_exp_q  <= fe_exp_d;
            fe_got_q  <= fe_got_d;
        end
    end

    // ------------------------------------------------------------------
    // Outputs (request fields forced to 0 when no request is pending)
    // ------------------------------------------------------------------
    assign cpu.cpu_rd      = req_rd;
    assign cpu.cpu_wr      = req_wr;
    assign cpu.cpu_addr    = req ? req_addr : '0;
    assign cpu.cpu_wr_be   = (state_q == S_INIT) ? '1 :
                             (req_wr ? be_q : '0);
    assign cpu.cpu_wr_data = (state_q == S_INIT) ? init_word :
                             (req_wr ? wdata_q : '0);

    assign busy           = (state_q == S_INIT) || (state_q == S_GEN) ||
                            (state_q == S_ISSUE);
    assign done           = (state_q == S_DONE);
    assign timeout        = timeout_q;
    assign err_count      = err_q;
    assign rd_count       = rd_q;
    assign wr_count       = wr_q;
    assign max_latency    = maxlat_q;
    assign first_err_addr = fe_addr_q;
    assign first_err_exp  = fe_exp_q;
    assign first_err_got  = fe_got_q;
endmodule

// File: tb/tb_cache_stress_gen.sv
// ----------------------------------------------------------------------------
// tb_cache_stress_gen
// Directed bench: a bench-side memory slave with selectable stall patterns,
// read corruption and a hang mode, driven through preload, random traffic,
// mid-run reset, start-while-busy, restart from DONE and timeout.
// ----------------------------------------------------------------------------
module tb_cache_stress_gen;
    localparam int unsigned AW    = 32;
    localparam int unsigned DW    = 32;
    localparam int unsigned SAW   = 10;
    localparam int          WORDS = 1 << SAW;
    localparam logic [31:0] BASE  = 32'h0000_4000;

    logic        clock = 1'b0;
    logic        reset_n;
    logic        start;
    logic [31:0] n_tests;
    logic        busy, done, timeout;
    logic [31:0] err_count, rd_count, wr_count;
    logic [15:0] max_latency;
    logic [31:0] first_err_addr, first_err_exp, first_err_got;

    cache_stress_gen_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    cache_stress_gen #(
        .ADDR_WIDTH (AW),
        .DATA_WIDTH (DW),
        .SHADOW_AW  (SAW),
        .BASE_ADDR  (BASE),
        .SEED       (32'h1),
        .RAND_BE    (1),
        .TIMEOUT    (16)
    ) dut (
        .clock          (clock),
        .reset_n        (reset_n),
        .start          (start),
        .n_tests        (n_tests),
        .busy           (busy),
        .done           (done),
        .timeout        (timeout),
        .err_count      (err_count),
        .rd_count       (rd_count),
        .wr_count       (wr_count),
        .max_latency    (max_latency),
        .first_err_addr (first_err_addr),
        .first_err_exp  (first_err_exp),
        .first_err_got  (first_err_got),
        .cpu            (bus.master)
    );

    always #5 clock = ~clock;

    // Slave control (driven from the stimulus block only)
    int   mode;        // 0 zero-wait, 1 wait = accept# mod 4, 2 hang on 5th random request
    logic corrupt_en;  // flip bit 0 of every 100th random read
    logic stat_clr;

    // Slave state (written only by the slave process)
    logic [31:0] mem [WORDS];
    int          acc_total, wcnt, max_lat_seen, init_bad, rng_bad, part_be;
    int          rnd_rd, rnd_wr, hang_cycles, inj_cnt;
    logic [31:0] first_inj_addr, first_inj_data;

    logic           req, hang_now, corrupt_now;
    int             target;
    logic [SAW-1:0] sidx;

    assign req = bus.cpu_rd | bus.cpu_wr;

    always_comb begin
        sidx        = SAW'((bus.cpu_addr - BASE) >> 2);
        hang_now    = (mode == 2) && (acc_total >= WORDS) && ((rnd_rd + rnd_wr) == 4);
        target      = (mode == 1) ? (acc_total % 4) : 0;
        corrupt_now = corrupt_en && bus.cpu_rd && (acc_total >= WORDS) &&
                      ((rnd_rd % 100) == 99);
        bus.cpu_waitrequest = req && (hang_now || (wcnt < target));
        bus.cpu_rd_data     = mem[sidx] ^ {31'b0, corrupt_now};
    end

    always @(posedge clock) begin
        if (stat_clr) begin
            acc_total    <= 0;
            wcnt         <= 0;
            max_lat_seen <= 0;
            init_bad     <= 0;
            rng_bad      <= 0;
            part_be      <= 0;
            rnd_rd       <= 0;
            rnd_wr       <= 0;
            hang_cycles  <= 0;
            inj_cnt      <= 0;
        end else if (req) begin
            if (!bus.cpu_waitrequest) begin
                acc_total <= acc_total + 1;
                wcnt      <= 0;
                if (wcnt + 1 > max_lat_seen) max_lat_seen <= wcnt + 1;
                if ((bus.cpu_addr < BASE) || (bus.cpu_addr >= BASE + 32'(WORDS * 4)) ||
                    (bus.cpu_addr[1:0] != 2'b00) || (bus.cpu_rd && bus.cpu_wr))
                    rng_bad <= rng_bad + 1;
                if (bus.cpu_wr) begin
                    for (int b = 0; b < 4; b++) begin
                        if (bus.cpu_wr_be[b]) mem[sidx][8*b +: 8] <= bus.cpu_wr_data[8*b +: 8];
                    end
                end
                if (acc_total < WORDS) begin
                    if (!(bus.cpu_wr && !bus.cpu_rd &&
                          bus.cpu_addr == BASE + 32'(acc_total) * 32'd4 &&
                          bus.cpu_wr_data == (32'hA500_0000 | 32'(acc_total)) &&
                          bus.cpu_wr_be == 4'hF))
                        init_bad <= init_bad + 1;
                end else if (bus.cpu_rd) begin
                    rnd_rd <= rnd_rd + 1;
                    if (corrupt_now) begin
                        inj_cnt <= inj_cnt + 1;
                        if (inj_cnt == 0) begin
                            first_inj_addr <= bus.cpu_addr;
                            first_inj_data <= bus.cpu_rd_data;
                        end
                    end
                end else begin
                    rnd_wr <= rnd_wr + 1;
                    if (bus.cpu_wr_be == 4'h0) rng_bad <= rng_bad + 1;
                    if (bus.cpu_wr_be != 4'hF) part_be <= part_be + 1;
                end
            end else begin
                wcnt <= wcnt + 1;
                if (hang_now) hang_cycles <= hang_cycles + 1;
            end
        end else begin
            wcnt <= 0;
        end
    end

    int n_checks = 0;
    int n_err    = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic clear_stats();
        stat_clr = 1'b1;
        @(negedge clock);
        stat_clr = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clock);
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        int k;
        k = 0;
        while (done !== 1'b1 && k < budget) begin
            @(negedge clock);
            k++;
        end
    endtask

    task automatic wait_acc(input int goal, input int budget);
        int k;
        k = 0;
        while (acc_total < goal && k < budget) begin
            @(negedge clock);
            k++;
        end
    endtask

    logic [31:0] snap;

    initial begin
        reset_n    = 1'b0;
        start      = 1'b0;
        n_tests    = 32'd0;
        mode       = 0;
        corrupt_en = 1'b0;
        stat_clr   = 1'b1;
        repeat (3) @(negedge clock);
        stat_clr   = 1'b0;

        // Reset state
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_timeout", timeout, 0);
        check("rst_counts", {err_count, rd_count}, 0);
        check("rst_wr_maxlat", {wr_count, 16'h0, max_latency}, 0);
        check("rst_cpu_req", {bus.cpu_rd, bus.cpu_wr, bus.cpu_addr}, 0);
        check("rst_first_err", {first_err_addr, first_err_exp | first_err_got}, 0);
        reset_n = 1'b1;
        @(negedge clock);

        // Preload at zero wait, endless run, aborted by reset
        clear_stats();
        mode    = 0;
        n_tests = 32'd0;
        pulse_start();
        wait_acc(WORDS + 200, 4000);
        check("A_progress", acc_total >= WORDS + 200, 1);
        check("A_init_writes", init_bad, 0);
        check("A_range", rng_bad, 0);
        check("A_busy", busy, 1);
        check("A_rd_count", rd_count, rnd_rd);
        check("A_wr_count", wr_count, rnd_wr);
        check("A_err", err_count, 0);
        check("A_maxlat", max_latency, 1);
        reset_n = 1'b0;
        #1;
        check("A_rst_busy", busy, 0);
        check("A_rst_counts", {rd_count, wr_count}, 0);
        check("A_rst_req", {bus.cpu_rd, bus.cpu_wr, bus.cpu_addr}, 0);
        check("A_rst_maxlat", max_latency, 0);
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);

        // Stalling slave, 300 random transactions
        clear_stats();
        mode    = 1;
        n_tests = 32'd300;
        pulse_start();
        wait_done(10000);
        check("B_done", done, 1);
        check("B_busy", busy, 0);
        check("B_total", rd_count + wr_count, 300);
        check("B_rd_count", rd_count, rnd_rd);
        check("B_wr_count", wr_count, rnd_wr);
        check("B_err", err_count, 0);
        check("B_maxlat", max_latency, 4);
        check("B_maxlat_seen", max_lat_seen, 4);
        check("B_init_writes", init_bad, 0);
        check("B_range_be", rng_bad, 0);
        check("B_partial_be", part_be > 0, 1);
        check("B_idle_bus", {bus.cpu_rd, bus.cpu_wr}, 0);

        // Restart from DONE with read corruption, start pulsed mid-run
        clear_stats();
        mode       = 0;
        corrupt_en = 1'b1;
        n_tests    = 32'd1000;
        pulse_start();
        check("C_clr_counts", {rd_count, wr_count}, 0);
        check("C_clr_maxlat", {err_count, 16'h0, max_latency}, 0);
        check("C_state", {busy, done}, 2'b10);
        check("C_first_req", {bus.cpu_wr, bus.cpu_addr}, {1'b1, BASE});
        wait_acc(WORDS + 400, 4000);
        snap = rd_count + wr_count;
        pulse_start();
        check("C_start_ignored", (rd_count + wr_count) >= snap && snap > 32'd100, 1);
        check("C_still_busy", busy, 1);
        wait_done(8000);
        check("C_done", done, 1);
        check("C_total", rd_count + wr_count, 1000);
        check("C_err_vs_inj", err_count, inj_cnt);
        check("C_err_vs_reads", err_count, rnd_rd / 100);
        check("C_inj_seen", inj_cnt > 0, 1);
        check("C_first_addr", first_err_addr, first_inj_addr);
        check("C_first_got", first_err_got, first_inj_data);
        check("C_first_exp", first_err_exp, first_inj_data ^ 32'h1);
        corrupt_en = 1'b0;

        // Slave hangs on the 5th random request
        clear_stats();
        mode    = 2;
        n_tests = 32'd100;
        pulse_start();
        wait_done(4000);
        check("D_done", {done, busy}, 2'b10);
        check("D_timeout", timeout, 1);
        check("D_req_dropped", {bus.cpu_rd, bus.cpu_wr}, 0);
        check("D_total", rd_count + wr_count, 4);
        check("D_rd_count", rd_count, rnd_rd);
        check("D_hang_cycles", hang_cycles, 16);
        check("D_maxlat", max_latency, 1);
        repeat (30) @(negedge clock);
        check("D_frozen", {rd_count + wr_count, 31'h0, timeout}, {32'd4, 32'd1});

        // Start from DONE clears the timeout flag
        clear_stats();
        mode    = 0;
        n_tests = 32'd20;
        pulse_start();
        check("E_timeout_clr", timeout, 0);
        check("E_busy", busy, 1);
        wait_done(3000);
        check("E_done", done, 1);
        check("E_total", rd_count + wr_count, 20);
        check("E_err", err_count, 0);
        check("E_range", rng_bad, 0);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end
endmodule
